sort_bus_slave: RTL
===================

Name: sort_bus_slave

Overview:
- Memory-mapped responder on the 32-bit split-request/response bus driven by udm (the bus initiator).
- Holds an ELEMS-entry array of 32-bit words and sorts it in place, ascending, with a sequential odd-even transposition engine.
- Host flow: load the words over the bus, write START, poll STATUS, read the result.
- Stalls the initiator via ack while the sort engine is busy.

Parameters:
- BASE_ADDR, 32'h00001000: byte base address of the 64-byte register window; must be 64-byte aligned.
- ELEMS, 8: number of array entries; even, 2..8.
- SIGNED, 0: 0 = unsigned compare; 1 = two's-complement compare.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous reset, active-high
- bus_req_i  input  1  request valid
- bus_we_i  input  1  1 = write, 0 = read
- bus_addr_bi  input  32  byte address
- bus_be_bi  input  4  byte enables for writes
- bus_wdata_bi  input  32  write data
- bus_ack_o  output  1  request accepted (combinational)
- bus_resp_o  output  1  read response valid (registered)
- bus_rdata_bo  output  32  read data, valid when bus_resp_o=1

Behaviour:
- Clock and reset: one clock, clk_i; rst_i is synchronous and active-high.
- Window: hit = (bus_addr_bi[31:6] == BASE_ADDR[31:6]). Outside the window, bus_ack_o=0 and no state changes.
- Register offsets (addr[5:0]):
  - 0x00 CTRL (W): bit0 START, written only if bus_be_bi[0]=1.
  - 0x04 STATUS (R): bit0 BUSY, bit1 DONE, other bits 0.
  - 0x20 + 4*i DATA[i] (R/W), i < ELEMS.
  - All other offsets: writes ignored; reads return 0 with a response.
- ack: bus_ack_o = bus_req_i & hit & !(BUSY & DATA offset). CTRL and STATUS always ack. A DATA access during BUSY holds ack low until BUSY falls; the initiator keeps req/addr/we/wdata stable while waiting.
- Write accepted (req & ack & we): DATA[i] bytes updated per bus_be_bi. Any DATA write clears DONE.
- Read accepted (req & ack & !we):
  - Next cycle: bus_resp_o=1 for exactly one cycle, with bus_rdata_bo = addressed value.
  - Otherwise bus_resp_o=0 and bus_rdata_bo=0.
  - Back-to-back reads give back-to-back responses. Read latency is always 1 cycle after ack.
- FSM IDLE -> SORT -> IDLE; phase counter width is clog2(ELEMS).
  - IDLE: an accepted CTRL write with wdata[0]=1 and be[0]=1 -> SORT, phase=0, DONE<=0.
  - SORT: one phase per cycle.
    - Even phase: compare-swap pairs (0,1),(2,3),…
    - Odd phase: compare-swap pairs (1,2),(3,4),…
    - Swap when a[j] > a[j+1] under the SIGNED rule.
    - After phase ELEMS-1 -> IDLE, DONE<=1.
  - BUSY = (state==SORT).
- Latency: START accepted in cycle T -> BUSY=1 from T+1 through T+ELEMS. Array final and DONE=1, BUSY=0 from T+ELEMS+1. For ELEMS=8 that is 8 busy cycles.
- START while BUSY: write is acked and ignored; the sort is not restarted.
- STATUS read in the same cycle the FSM leaves SORT: returns the pre-edge value (BUSY=1, DONE=0).
- Equal elements: no swap, so the sort is stable for equal keys.
- Reset (including mid-sort): state=IDLE, phase=0, all DATA=0, BUSY=0, DONE=0, bus_resp_o=0, bus_rdata_bo=0. bus_ack_o follows its combinational rule from the first cycle after reset.

Test Plan:
- Reset, then read STATUS, DATA[0], and unmapped offset 0x10 -> each gives resp one cycle after ack with rdata 0. Access at BASE_ADDR+0x40 -> ack stays 0, no resp.
- Write DATA[0..7] = 7,3,9,1,8,2,6,4; write CTRL=1 -> BUSY exactly 8 cycles. Then DONE=1, DATA reads 1,2,3,4,6,7,8,9.
- SIGNED=1, data = 5, -1, 0, 32'h80000000, 3, 3, -7, 2 -> result 32'h80000000, -7, -1, 0, 2, 3, 3, 5. Same data with SIGNED=0 -> 0, 2, 3, 3, 5, 32'h80000000, -7, -1.
- Read DATA[2] one cycle after START -> ack held low for 8 cycles, then ack. resp arrives the next cycle with the sorted value. STATUS reads during the stall ack immediately with BUSY=1.
- Write DATA[1]=32'hAABBCCDD with be=4'b0101 over old value 32'h11223344 -> readback 32'h11BB33DD. DONE cleared by the write.
- Assert rst_i on sort cycle 4 -> next cycle BUSY=0, DONE=0, all DATA=0. A new START sorts normally.

Source files
------------

// File: rtl/sort_bus_slave.sv
// sort_bus_slave: bus-mapped array of ELEMS 32-bit words sorted in place,
// ascending, by a sequential odd-even transposition engine (one phase per
// clock). The host loads DATA, writes START, polls STATUS and reads back.
// DATA accesses are stalled (ack low) while the engine owns the array.
module sort_bus_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          ELEMS     = 8,
    parameter bit          SIGNED    = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo
);

    // Phase counter and array index share the same width.
    localparam int            PW         = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(ELEMS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SORT = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [PW-1:0] phase_r;
    logic          done_r;
    logic [31:0]   data_r   [ELEMS];
    logic [31:0]   sorted_s [ELEMS];
    logic [ELEMS:0] swap_s;          // swap_s[j+1] = swap pair (j, j+1)

    logic          hit_s;
    logic [5:0]    off_s;
    logic          is_ctrl_s;
    logic          is_status_s;
    logic          is_data_s;
    logic [PW-1:0] idx_s;
    logic          busy_s;
    logic          ack_s;
    logic          wr_acc_s;
    logic          rd_acc_s;
    logic          start_s;
    logic          data_wr_s;
    logic          last_phase_s;
    logic [31:0]   rd_mux_s;
    logic          resp_r;
    logic [31:0]   rdata_r;

    // Ordering rule used by the compare-swap cells.
    function automatic logic gt_f(input logic [31:0] a, input logic [31:0] b);
        logic res;
        if (SIGNED) begin
            res = ($signed(a) > $signed(b));
        end else begin
            res = (a > b);
        end
        return res;
    endfunction

    // Byte-lane merge of write data into an existing word.
    function automatic logic [31:0] merge_f(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    // Address decode and bus handshake qualifiers.
    always_comb begin
        off_s        = bus_addr_bi[5:0];
        hit_s        = (bus_addr_bi[31:6] == BASE_ADDR[31:6]);
        is_ctrl_s    = (off_s == 6'h00);
        is_status_s  = (off_s == 6'h04);
        is_data_s    = off_s[5] && (off_s[1:0] == 2'b00) &&
                       ({1'b0, off_s[4:2]} < 4'(ELEMS));
        idx_s        = PW'(off_s[4:2]);
        busy_s       = (state_r == ST_SORT);
        ack_s        = bus_req_i && hit_s && !(busy_s && is_data_s);
        wr_acc_s     = ack_s && bus_we_i;
        rd_acc_s     = ack_s && !bus_we_i;
        start_s      = wr_acc_s && is_ctrl_s && bus_be_bi[0] && bus_wdata_bi[0];
        data_wr_s    = wr_acc_s && is_data_s;
        last_phase_s = (phase_r == LAST_PHASE);
    end

    // Per-pair swap decisions: even phases pair (0,1),(2,3)..., odd phases (1,2),(3,4)...
    // Equal keys never swap, which keeps the sort stable.
    always_comb begin
        swap_s = '0;
        for (int j = 0; j < ELEMS - 1; j++) begin
            if (j[0] == phase_r[0]) begin
                swap_s[j+1] = gt_f(data_r[j], data_r[j+1]);
            end else begin
                swap_s[j+1] = 1'b0;
            end
        end
    end

    // Array contents after applying this phase's swaps.
    always_comb begin
        for (int k = 0; k < ELEMS; k++) begin
            if (swap_s[k]) begin
                sorted_s[k] = data_r[(k == 0) ? 0 : k - 1];
            end else if (swap_s[k+1]) begin
                sorted_s[k] = data_r[(k == ELEMS - 1) ? k : k + 1];
            end else begin
                sorted_s[k] = data_r[k];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: START only honoured from IDLE; SORT runs ELEMS phases.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_SORT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SORT: begin
                if (last_phase_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SORT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Phase counter: advances once per SORT cycle, parked at zero otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_r <= '0;
        end else if ((state_r == ST_SORT) && !last_phase_s) begin
            phase_r <= phase_r + PW'(1);
        end else begin
            phase_r <= '0;
        end
    end

    // DONE flag: set when the last phase retires, cleared by START or any DATA write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_r <= 1'b0;
        end else if ((state_r == ST_SORT) && last_phase_s) begin
            done_r <= 1'b1;
        end else if ((state_r == ST_IDLE) && start_s) begin
            done_r <= 1'b0;
        end else if (data_wr_s) begin
            done_r <= 1'b0;
        end else begin
            done_r <= done_r;
        end
    end

    // Data array: the engine owns it while busy, otherwise bus writes update bytes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ELEMS; i++) begin
                data_r[i] <= 32'h0;
            end
        end else if (busy_s) begin
            data_r <= sorted_s;
        end else if (data_wr_s) begin
            data_r[idx_s] <= merge_f(data_r[idx_s], bus_wdata_bi, bus_be_bi);
        end else begin
            data_r <= data_r;
        end
    end

    // Read data selection for an accepted read.
    always_comb begin
        rd_mux_s = 32'h0;
        if (is_status_s) begin
            rd_mux_s = {30'h0, done_r, busy_s};
        end else if (is_data_s) begin
            rd_mux_s = data_r[idx_s];
        end else begin
            rd_mux_s = 32'h0;
        end
    end

    // Read response: one cycle after acceptance, data zero when no response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_r  <= 1'b0;
            rdata_r <= 32'h0;
        end else begin
            resp_r  <= rd_acc_s;
            rdata_r <= rd_acc_s ? rd_mux_s : 32'h0;
        end
    end

    assign bus_ack_o    = ack_s;
    assign bus_resp_o   = resp_r;
    assign bus_rdata_bo = rdata_r;

endmodule
